spi_master_xfer: RTL and testbench

Parametrised, single-clock SPI master: the successor to the fixed 4-byte, mode-0, ungated-divider SPI path used for flash address reads. It runs one chip-select-framed transfer of 0..MAX_BYTES bytes, full duplex, with a programmable SCLK divider, all four CPOL/CPHA modes, programmable CS setup/hold, and a start/busy/done handshake. It sits between the core's fetch/load logic and the external SPI flash/RAM pins. SCLK is a registered data output; no internal logic is clocked by it.

---
 rtl/spi_master_xfer.sv | 112 +++++++++++
 tb/tb_spi_master_xfer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master_xfer.sv
// spi_master_xfer: CS-framed full-duplex SPI master, 0..MAX_BYTES bytes, all CPOL/CPHA modes, programmable SCLK divider
module spi_master_xfer #(
  parameter int MAX_BYTES = 8,
  parameter int DIV_W     = 8,
  parameter int CS_SETUP  = 5,
  parameter int CS_HOLD   = 8,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic [DIV_W-1:0]       clk_div,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  output logic [8*MAX_BYTES-1:0] rx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   sclk,
  output logic                   mosi,
  output logic                   cs,
  input  logic                   miso
);
  localparam int W    = 8 * MAX_BYTES;
  localparam int HC_W = $clog2(16 * MAX_BYTES + 1);
  localparam int TW   = $clog2((CS_SETUP > CS_HOLD ? CS_SETUP : CS_HOLD) + 1);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_d;
  logic [LEN_W-1:0] len_c, len_q;
  logic             cpol_q, cpha_q;
  logic [DIV_W-1:0] div_q, dc;
  logic [W-1:0]     tx_sh, rx_sh;
  logic [HC_W-1:0]  hc, last_h;
  logic [TW-1:0]    tmr;
  logic accept, tmr_end, half_end, last_half, go_shift, next_half, shift_end;
  logic edge_go, lead, sample, present, finish;
  always_comb begin
    len_c     = len > LEN_W'(MAX_BYTES) ? LEN_W'(MAX_BYTES) : len;
    last_h    = HC_W'({len_q, 4'b0}) - HC_W'(1);
    accept    = state == IDLE && start;
    tmr_end   = tmr == '0;
    half_end  = dc == '0;
    last_half = hc == last_h;
    go_shift  = state == SETUP && tmr_end;
    next_half = state == SHIFT && half_end && !last_half;
    shift_end = state == SHIFT && half_end && last_half;
    finish    = state == HOLD && tmr_end;
    edge_go   = go_shift || next_half;
    // the half-period about to start is a leading one whenever sclk still sits at idle
    lead      = sclk == cpol_q;
    sample    = edge_go && (lead != cpha_q);
    present   = edge_go && (cpha_q ? lead : !lead && hc + HC_W'(1) != last_h);
    state_d   = accept ? (len_c == '0 ? HOLD : SETUP) :
                go_shift ? SHIFT : shift_end ? HOLD : finish ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      dc      <= '0;
      hc      <= '0;
      tmr     <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b1;
    end else begin
      done <= finish;
      if (accept) begin
        len_q  <= len_c;
        cpol_q <= cpol;
        cpha_q <= cpha;
        div_q  <= clk_div;
        tx_sh  <= cpha ? tx_data : tx_data << 1;
        mosi   <= !cpha && len_c != '0 && tx_data[W-1];
        rx_sh  <= '0;
        busy   <= 1'b1;
        cs     <= len_c == '0;
        sclk   <= cpol;
        tmr    <= len_c == '0 ? '0 : TW'(CS_SETUP - 1);
      end
      if ((state == SETUP || state == HOLD) && !tmr_end) tmr <= tmr - TW'(1);
      if (shift_end) tmr <= TW'(CS_HOLD - 1);
      if (edge_go) begin
        hc   <= go_shift ? '0 : hc + HC_W'(1);
        dc   <= div_q;
        sclk <= ~sclk;
      end else if (state == SHIFT) dc <= dc - DIV_W'(1);
      if (sample) rx_sh <= {rx_sh[W-2:0], miso};
      if (present) begin
        mosi  <= tx_sh[W-1];
        tx_sh <= tx_sh << 1;
      end
      if (finish) begin
        cs      <= 1'b1;
        busy    <= 1'b0;
        mosi    <= 1'b0;
        rx_data <= rx_sh;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_xfer.sv
// tb_spi_master_xfer: randomized and directed check of spi_master_xfer against a cycle-indexed behavioural model
module tb_spi_master_xfer;
  localparam int MB = 8, W = 64, CS_S = 5, CS_H = 8;
  logic clk = 0, rst = 1, start = 0, cpol = 0, cpha = 0, miso;
  logic [3:0] len = '0;
  logic [7:0] clk_div = '0;
  logic [W-1:0] tx_data = '0, rx_data, pat = '0;
  logic loop_sel = 0;
  logic busy, done, sclk, mosi, cs;
  int errors = 0, checks = 0;
  spi_master_xfer #(.MAX_BYTES(MB), .DIV_W(8), .CS_SETUP(CS_S), .CS_HOLD(CS_H)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso));
  always #5 clk = ~clk;
  // model: m_c counts cycles since the accepting edge
  logic m_act = 0, m_cpol = 0, m_cpha = 0, m_loop = 0;
  int m_len = 0, m_div = 0, m_c = 0;
  logic [W-1:0] m_tx = '0, m_pat = '0, rx_exp = '0;
  function automatic int tend(input int l, input int dv);
    return l == 0 ? 1 : CS_S + 16 * l * (dv + 1) + CS_H;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_cpol = 0; rx_exp = '0;
    end else if (!(m_act && m_c < tend(m_len, m_div)) && start) begin
      m_act = 1; m_c = 0; m_len = len > 8 ? 8 : int'(len); m_div = int'(clk_div);
      m_cpol = cpol; m_cpha = cpha; m_tx = tx_data; m_pat = pat; m_loop = loop_sel;
    end else if (m_act) begin
      m_c++;
      if (m_c == tend(m_len, m_div)) rx_exp = (m_loop ? m_tx : m_pat) >> (W - 8 * m_len);
      if (m_c > tend(m_len, m_div)) m_act = 0;
    end
  end
  // slave: drives pat MSB-first on its shift edges, captures mosi on its sample edges
  logic cs_q = 1, sclk_q = 0, slv_miso = 0, lead;
  int sidx = 0;
  logic [W-1:0] cap = '0;
  assign miso = m_loop ? mosi : slv_miso;
  always @(negedge cs or sclk) begin
    if (!cs && cs_q) begin
      sidx = 0; cap = '0; slv_miso = m_cpha ? 1'b0 : m_pat[W-1];
    end else if (!cs && !cs_q) begin
      lead = sclk != m_cpol;
      if (lead != m_cpha) cap = {cap[W-2:0], mosi};
      else if (m_cpha) begin slv_miso = m_pat[W-1-sidx]; sidx++; end
      else begin sidx++; slv_miso = sidx < W ? m_pat[W-1-sidx] : 1'b0; end
    end
  end
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  logic chk_on = 0;
  int rises = 0, togs = 0, cs_low = 0, dones = 0, hi_run = 0, last_hi = 0;
  task automatic tick();
    int l, d, te, nt, ix;
    logic e_cs, e_busy, e_done, e_sclk, e_mosi;
    @(negedge clk);
    if (chk_on) begin
      {e_cs, e_busy, e_done, e_sclk, e_mosi} = {1'b1, 1'b0, 1'b0, m_cpol, 1'b0};
      if (m_act) begin
        l = m_len; d = m_div + 1; te = tend(l, m_div);
        e_busy = m_c < te; e_done = m_c == te; e_cs = l == 0 || m_c >= te;
        nt = (l == 0 || m_c < CS_S) ? 0 : (m_c - CS_S) / d + 1;
        if (nt > 16 * l) nt = 16 * l;
        e_sclk = m_cpol ^ (nt % 2 == 1);
        if (!e_cs) begin
          ix = m_cpha ? (nt + 1) / 2 - 1 : (nt / 2 > 8 * l - 1 ? 8 * l - 1 : nt / 2);
          e_mosi = (m_cpha && nt == 0) ? 1'b0 : m_tx[W-1-ix];
        end
      end
      chk("cs", {63'b0, cs}, {63'b0, e_cs});
      chk("busy", {63'b0, busy}, {63'b0, e_busy});
      chk("done", {63'b0, done}, {63'b0, e_done});
      chk("sclk", {63'b0, sclk}, {63'b0, e_sclk});
      chk("mosi", {63'b0, mosi}, {63'b0, e_mosi});
      chk("rx_data", rx_data, rx_exp);
    end
    if (!cs && !cs_q && sclk && !sclk_q) rises++;
    if (sclk !== sclk_q) togs++;
    if (!cs) cs_low++;
    if (done) dones++;
    if (cs) hi_run++;
    else begin
      if (cs_q) last_hi = hi_run;
      hi_run = 0;
    end
    cs_q = cs; sclk_q = sclk;
    @(posedge clk); #1;
  endtask
  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    if (n >= 3000) chk({nm, "_timeout"}, 64'(n), 64'(0));
  endtask
  task automatic go(input int l, input logic pl, input logic ph, input int dv,
                    input logic [W-1:0] tx, input logic [W-1:0] pt, input logic lp);
    len = 4'(l); cpol = pl; cpha = ph; clk_div = 8'(dv); tx_data = tx; pat = pt; loop_sel = lp;
    start = 1; tick(); start = 0;
  endtask
  int n, b_low, b_rise, b_tog, b_done;
  task automatic mark();
    b_low = cs_low; b_rise = rises; b_tog = togs; b_done = dones;
  endtask
  initial begin
    repeat (3) tick();
    chk_on = 1;
    tick();
    rst = 0;
    chk("rst_cs", {63'b0, cs}, 64'd1);
    chk("rst_sclk", {63'b0, sclk}, 64'd0);
    chk("rst_rx", rx_data, 64'd0);
    repeat (3) tick();
    mark();
    go(4, 0, 0, 0, {32'h0312_3456, 32'h0}, '0, 1); wait_done("t1", n); tick();
    chk("t1_lat", 64'(n), 64'd77);
    chk("t1_rx", rx_data, 64'h0000_0000_0312_3456);
    chk("t1_cs_low", 64'(cs_low - b_low), 64'd77);
    chk("t1_rises", 64'(rises - b_rise), 64'd32);
    chk("t1_dones", 64'(dones - b_done), 64'd1);
    mark();
    go(1, 1, 1, 3, {8'hA5, 56'h0}, {8'h3C, 56'h0}, 0); wait_done("t2", n); tick();
    chk("t2_rx", rx_data, 64'h3C);
    chk("t2_cs_low", 64'(cs_low - b_low), 64'd77);
    chk("t2_rises", 64'(rises - b_rise), 64'd8);
    chk("t2_cap", {56'h0, cap[7:0]}, 64'hA5);
    chk("t2_idle_sclk", {63'b0, sclk}, 64'd1);
    go(2, 0, 1, 1, {16'hBEEF, 48'h0}, '0, 1); wait_done("m1", n); tick();
    chk("m1_rx", rx_data, 64'hBEEF);
    go(2, 1, 0, 2, {16'hBEEF, 48'h0}, '0, 1); wait_done("m2", n); tick();
    chk("m2_rx", rx_data, 64'hBEEF);
    mark();
    go(4, 0, 0, 0, {32'h0312_3456, 32'h0}, '0, 1);
    repeat (30) tick();
    start = 1; tx_data = {$urandom, $urandom}; len = 1; clk_div = 2; cpol = 1; cpha = 1;
    tick(); start = 0;
    wait_done("mid", n); tick();
    chk("mid_rx", rx_data, 64'h0312_3456);
    chk("mid_dones", 64'(dones - b_done), 64'd1);
    mark();
    go(0, 0, 0, 0, {$urandom, $urandom}, '0, 1); wait_done("l0", n); tick();
    chk("l0_lat", 64'(n), 64'd1);
    chk("l0_cs_low", 64'(cs_low - b_low), 64'd0);
    chk("l0_togs", 64'(togs - b_tog), 64'd0);
    chk("l0_dones", 64'(dones - b_done), 64'd1);
    mark();
    go(9, 0, 0, 0, 64'hF00D_CAFE_1234_5678, '0, 1); wait_done("l9", n); tick();
    chk("l9_rx", rx_data, 64'hF00D_CAFE_1234_5678);
    chk("l9_cs_low", 64'(cs_low - b_low), 64'd141);
    chk("l9_rises", 64'(rises - b_rise), 64'd64);
    mark();
    go(4, 0, 0, 1, 64'h1357_9BDF_0000_0000, '0, 1);
    n = 0;
    while (rises - b_rise < 10 && n < 2000) begin tick(); n++; end
    chk("rst_wait", 64'(n < 2000), 64'd1);
    rst = 1; tick(); rst = 0;
    chk("mid_rst_cs", {63'b0, cs}, 64'd1);
    chk("mid_rst_sclk", {63'b0, sclk}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_rx", rx_data, 64'd0);
    repeat (100) tick();
    chk("mid_rst_nodone", 64'(dones - b_done), 64'd0);
    go(1, 0, 0, 0, {8'h5A, 56'h0}, '0, 1); wait_done("post", n);
    start = 1; tx_data = {8'h96, 56'h0}; tick(); start = 0; tick();
    chk("post_rx", rx_data, 64'h5A);
    chk("b2b_hi", 64'(last_hi), 64'd1);
    wait_done("b2b", n); tick();
    chk("b2b_rx", rx_data, 64'h96);
    repeat (30) begin
      go($urandom_range(0, 9), 1'($urandom), 1'($urandom), $urandom_range(0, 2),
         {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      wait_done("rnd", n);
      if ($urandom_range(0, 1) == 1) tick();
    end
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
